// File: rtl/pin_entry_collector_pkg.sv
// rtl/pin_entry_collector_pkg.sv - shared key codes, state encoding and helpers for the PIN collector
package pin_entry_collector_pkg;

  localparam int DIGITS = 4;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [1:0] {
    PE_IDLE    = 2'd0,
    PE_COLLECT = 2'd1,
    PE_PRESENT = 2'd2
  } pe_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entry_collector_if.sv
// rtl/pin_entry_collector_if.sv - keystroke input and PIN output bundle between keypad and gate controller
interface pin_entry_collector_if;

  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] code;
  logic        code_ack;

  modport master (output key_valid, output key_code, input code, input code_ack);
  modport slave  (input key_valid, input key_code, output code, output code_ack);

endinterface

// File: rtl/pin_idle_timer.sv
// rtl/pin_idle_timer.sv - clearable up-counter; o_tc fires on the edge the count would reach TERMINAL
module pin_idle_timer #(
  parameter int TIMER_W  = 16,
  parameter int TERMINAL = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_tc
);

  localparam logic [TIMER_W-1:0] TC = TIMER_W'(TERMINAL);

  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] w_count_inc;

  assign w_count_inc = r_count + TIMER_W'(1);
  // Terminal count wraps to zero so the owner never has to clear it separately.
  assign o_tc        = i_count_en && (w_count_inc == TC);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || o_tc) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= w_count_inc;
    end
  end

endmodule

// File: rtl/pin_entry_collector.sv
// rtl/pin_entry_collector.sv - collects four BCD keystrokes into a 16-bit PIN and presents it with a fixed-length ack
module pin_entry_collector
  import pin_entry_collector_pkg::*;
#(
  parameter int ACK_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  pin_entry_collector_if.slave        bus,
  output logic                        o_entry_error,
  output logic [2:0]                  o_digit_count
);

  pe_state_t   r_state, w_state_nxt;
  logic [15:0] r_buffer, w_buffer_nxt;
  logic [15:0] r_code, w_code_nxt;
  logic [2:0]  r_count, w_count_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_err, w_err_nxt;

  logic w_is_digit, w_is_clear, w_is_enter, w_key_accept;
  logic w_idle_clear, w_idle_en, w_idle_tc;
  logic w_ack_en, w_ack_tc;

  assign w_is_digit   = bus.key_valid && is_digit(bus.key_code);
  assign w_is_clear   = bus.key_valid && (bus.key_code == KEY_CLEAR);
  assign w_is_enter   = bus.key_valid && (bus.key_code == KEY_ENTER);
  assign w_key_accept = w_is_digit || w_is_clear || w_is_enter;

  // Codes C-F neither reset nor pause the idle timer.
  assign w_idle_en    = (r_state == PE_COLLECT) && i_enable && (r_count != 3'd0) && !w_key_accept;
  assign w_idle_clear = (r_state != PE_COLLECT) || !i_enable || (r_count == 3'd0) || w_key_accept;
  assign w_ack_en     = (r_state == PE_PRESENT);

  pin_idle_timer #(.TIMER_W(TIMER_W), .TERMINAL(TIMEOUT_CYCLES)) u_idle_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_idle_clear),
    .i_count_en (w_idle_en),
    .o_tc       (w_idle_tc)
  );

  pin_idle_timer #(.TIMER_W(TIMER_W), .TERMINAL(ACK_CYCLES)) u_ack_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (!w_ack_en),
    .i_count_en (w_ack_en),
    .o_tc       (w_ack_tc)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_buffer_nxt = r_buffer;
    w_count_nxt  = r_count;
    w_code_nxt   = r_code;
    w_ack_nxt    = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      PE_IDLE: begin
        if (i_enable) begin
          w_state_nxt  = PE_COLLECT;
          w_buffer_nxt = '0;
          w_count_nxt  = '0;
        end
      end
      PE_COLLECT: begin
        if (!i_enable) begin
          w_state_nxt  = PE_IDLE;
          w_buffer_nxt = '0;
          w_count_nxt  = '0;
        end else if (w_is_digit) begin
          if (r_count < 3'(DIGITS)) begin
            w_buffer_nxt = {r_buffer[11:0], bus.key_code};
            w_count_nxt  = r_count + 3'd1;
          end
        end else if (w_is_clear) begin
          w_buffer_nxt = '0;
          w_count_nxt  = '0;
        end else if (w_is_enter) begin
          if (r_count == 3'(DIGITS)) begin
            w_code_nxt  = r_buffer;
            w_ack_nxt   = 1'b1;
            w_state_nxt = PE_PRESENT;
          end else begin
            w_err_nxt    = 1'b1;
            w_buffer_nxt = '0;
            w_count_nxt  = '0;
          end
        end else if (w_idle_tc) begin
          w_err_nxt    = 1'b1;
          w_buffer_nxt = '0;
          w_count_nxt  = '0;
        end
      end
      PE_PRESENT: begin
        if (!i_enable || w_ack_tc) begin
          w_state_nxt  = i_enable ? PE_COLLECT : PE_IDLE;
          w_buffer_nxt = '0;
          w_count_nxt  = '0;
        end else begin
          w_ack_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = PE_IDLE;
        w_buffer_nxt = '0;
        w_count_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= PE_IDLE;
      r_buffer <= '0;
      r_count  <= '0;
      r_code   <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_buffer <= w_buffer_nxt;
      r_count  <= w_count_nxt;
      r_code   <= w_code_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign bus.code      = r_code;
  assign bus.code_ack  = r_ack;
  assign o_entry_error = r_err;
  assign o_digit_count = r_count;

endmodule
